// File: rtl/asyn_fifo_read_ctrl.sv
// rtl/asyn_fifo_read_ctrl.sv - read-side controller of the dual-clock FIFO
module asyn_fifo_read_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  read_clk,
  input  logic                  read_rst,
  input  logic [ADDR_WIDTH:0]   write_ptr_gray,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic [ADDR_WIDTH:0]   read_ptr_gray,
  output logic                  read_empty,
  output logic [ADDR_WIDTH:0]   read_level,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wq1;
  logic [PW-1:0] wq2;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rgray;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] wbin_sync;
  logic          pop;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Two-flop synchroniser for the write pointer; nothing ahead of or between the flops
  always_ff @(posedge read_clk) begin
    if (read_rst) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= write_ptr_gray;
      wq2 <= wq1;
    end
  end

  // Empty, pop decision and level, all from registered state
  always_comb begin
    read_empty = (rgray == wq2);
    pop        = !read_empty && (!out_valid || out_ready);
    rbin_next  = rbin + 1'b1;
    wbin_sync  = gray2bin(wq2);
    read_level = wbin_sync - rbin;
  end

  // Read pointers advance on every pop; Gray copy kept registered for the write domain
  always_ff @(posedge read_clk) begin
    if (read_rst) begin
      rbin  <= '0;
      rgray <= '0;
    end else if (pop) begin
      rbin  <= rbin_next;
      rgray <= rbin_next ^ (rbin_next >> 1);
    end
  end

  // Show-ahead output register: load on pop, drop valid once the consumer takes the word
  always_ff @(posedge read_clk) begin
    if (read_rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= read_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign read_addr     = rbin[ADDR_WIDTH-1:0];
  assign read_ptr_gray = rgray;

endmodule

// File: tb/tb_asyn_fifo_read_ctrl.sv
// tb/tb_asyn_fifo_read_ctrl.sv - self-checking bench for asyn_fifo_read_ctrl
module tb_asyn_fifo_read_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          read_clk;
  logic          read_rst;
  logic [AW:0]   write_ptr_gray;
  logic [DW-1:0] read_data;
  logic [AW-1:0] read_addr;
  logic [AW:0]   read_ptr_gray;
  logic          read_empty;
  logic [AW:0]   read_level;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  logic [DW-1:0] ram [4];
  logic [AW:0]   wbin;
  logic [DW-1:0] sb [$];
  int            compared;
  int            mismatched;
  int            delivered;

  asyn_fifo_read_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .read_clk       (read_clk),
    .read_rst       (read_rst),
    .write_ptr_gray (write_ptr_gray),
    .read_data      (read_data),
    .read_addr      (read_addr),
    .read_ptr_gray  (read_ptr_gray),
    .read_empty     (read_empty),
    .read_level     (read_level),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  assign read_data = ram[read_addr];

  initial begin
    read_clk = 1'b0;
    forever #5 read_clk = ~read_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [DW-1:0] val);
    ram[wbin[AW-1:0]] = val;
    wbin = wbin + 1'b1;
    write_ptr_gray = wbin ^ (wbin >> 1);
    sb.push_back(val);
  endtask

  // One read_clk cycle: score a transfer happening at the coming edge, then advance
  task automatic cycle();
    logic [DW-1:0] exp;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", {31'd0, out_valid}, 32'd0);
      end else begin
        exp = sb.pop_front();
        check("out_data", {24'd0, out_data}, {24'd0, exp});
        delivered++;
      end
    end
    @(posedge read_clk);
    #1;
  endtask

  initial begin
    int budget;
    int next_val;
    int base;
    compared   = 0;
    mismatched = 0;
    delivered  = 0;
    wbin       = '0;
    for (int i = 0; i < 4; i++) ram[i] = '0;
    read_rst       = 1'b1;
    out_ready      = 1'b0;
    write_ptr_gray = '0;
    @(posedge read_clk); #1;
    @(posedge read_clk); #1;
    read_rst = 1'b0;

    // Test 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      check("t1_empty", {31'd0, read_empty}, 32'd1);
      check("t1_valid", {31'd0, out_valid}, 32'd0);
      check("t1_level", {29'd0, read_level}, 32'd0);
      check("t1_rgray", {29'd0, read_ptr_gray}, 32'd0);
      cycle();
    end

    // Test 2: three words with Gray 0->1->3->2, latency check on the first
    out_ready = 1'b1;
    write_word(8'hA1);
    cycle();
    check("t2_empty_n", {31'd0, read_empty}, 32'd1);
    check("t2_valid_n", {31'd0, out_valid}, 32'd0);
    cycle();
    check("t2_empty_n1", {31'd0, read_empty}, 32'd0);
    check("t2_valid_n1", {31'd0, out_valid}, 32'd0);
    write_word(8'hB2);
    cycle();
    check("t2_valid_n2", {31'd0, out_valid}, 32'd1);
    cycle();
    write_word(8'hC3);
    for (int i = 0; i < 8; i++) cycle();
    check("t2_delivered", delivered, 32'd3);
    check("t2_rgray", {29'd0, read_ptr_gray}, 32'b010);
    check("t2_empty_end", {31'd0, read_empty}, 32'd1);
    check("t2_sb_empty", sb.size(), 32'd0);

    // Test 3: fill all four slots with the consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      write_word(8'h30 + i[7:0]);
      cycle();
    end
    for (int i = 0; i < 4; i++) cycle();
    check("t3_valid", {31'd0, out_valid}, 32'd1);
    check("t3_level", {29'd0, read_level}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("t3_stable", {24'd0, out_data}, 32'h30);
      cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t3_drain_valid", {31'd0, out_valid}, 32'd1);
      cycle();
    end
    check("t3_valid_end", {31'd0, out_valid}, 32'd0);
    check("t3_empty_end", {31'd0, read_empty}, 32'd1);
    check("t3_sb_empty", sb.size(), 32'd0);

    // Test 4: 20 words across pointer wrap with random backpressure
    budget   = 0;
    next_val = 0;
    base     = delivered;
    while ((delivered - base < 20) && (budget < 3000)) begin
      out_ready = 1'($urandom_range(0, 1));
      if ((next_val < 20) && (sb.size() < 4) && ($urandom_range(0, 1) == 1)) begin
        write_word(next_val[7:0]);
        next_val++;
      end
      cycle();
      budget++;
    end
    check("t4_delivered", delivered - base, 32'd20);
    check("t4_sb_empty", sb.size(), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check("t4_level_end", {29'd0, read_level}, 32'd0);
    check("t4_empty_end", {31'd0, read_empty}, 32'd1);
    check("t4_rgray_end", {29'd0, read_ptr_gray}, {29'd0, wbin ^ (wbin >> 1)});

    // Test 5: reset mid-stream with a word held and two unread
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      write_word(8'h50 + i[7:0]);
      cycle();
    end
    for (int i = 0; i < 4; i++) cycle();
    check("t5_valid_pre", {31'd0, out_valid}, 32'd1);
    check("t5_level_pre", {29'd0, read_level}, 32'd2);
    read_rst       = 1'b1;
    wbin           = '0;
    write_ptr_gray = '0;
    sb.delete();
    cycle();
    check("t5_valid", {31'd0, out_valid}, 32'd0);
    check("t5_rgray", {29'd0, read_ptr_gray}, 32'd0);
    check("t5_addr", {30'd0, read_addr}, 32'd0);
    check("t5_level", {29'd0, read_level}, 32'd0);
    check("t5_empty", {31'd0, read_empty}, 32'd1);
    read_rst  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("t5_no_stale", {31'd0, out_valid}, 32'd0);
      cycle();
    end

    // Test 6: static write pointer, toggling consumer
    for (int i = 0; i < 10; i++) begin
      out_ready = i[0];
      check("t6_addr", {30'd0, read_addr}, 32'd0);
      check("t6_empty", {31'd0, read_empty}, 32'd1);
      check("t6_valid", {31'd0, out_valid}, 32'd0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
